rr_arbiter_hold_n: RTL and testbench

//   N-way round-robin arbiter for a shared resource with transaction hold.
//   A winner keeps its grant until it drops its request.
//   It arbitrates ownership of a shared datapath (bus, memory port, FIFO write side) among N requesters.

---
 rtl/rr_arbiter_hold_n.sv | 165 ++++++++++++++++
 tb/tb_rr_arbiter_hold_n.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_hold_n.sv
// N-way round-robin arbiter; the owner keeps its grant until it drops its request.
// Define RR_ARB_HOLD_LIMIT_EN to pre-empt an owner after MAX_HOLD cycles when others are waiting.
module rr_arbiter_hold_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic [N-1:0]   r_grant;
    logic [N-1:0]   w_grant_nx;
    logic           r_valid;
    logic [IW-1:0]  r_grant_id;
    logic [IW-1:0]  w_id_nx;
    logic [IW-1:0]  r_ptr;
    logic [IW-1:0]  w_ptr_nx;

    logic [N-1:0]   w_arb_req;
    logic [IW:0]    w_cand;
    logic           w_found;
    logic [IW-1:0]  w_win;

    logic           w_owner_req;
    logic           w_others;
    logic           w_keep;
    logic           w_do_arb;
    logic           w_release;

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0]  r_hold_cnt;
    logic [HW-1:0]  w_hold_nx;
    logic           w_limit;
`endif

    // r_grant is zero in IDLE, so masking it only excludes the current owner in GRANT.
    always_comb begin : arb_search
        w_arb_req = req & ~r_grant;
        w_found   = 1'b0;
        w_win     = '0;
        w_cand    = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_cand >= (IW+1)'(N)) begin
                w_cand = w_cand - (IW+1)'(N);
            end
            if (!w_found && w_arb_req[w_cand[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[IW-1:0];
            end
        end
    end

    always_comb begin : owner_status
        w_owner_req = req[r_grant_id];
        w_others    = |(req & ~r_grant);
`ifdef RR_ARB_HOLD_LIMIT_EN
        w_limit     = (r_hold_cnt == HOLD_LAST);
        w_keep      = w_owner_req && !(w_limit && w_others);
`else
        w_keep      = w_owner_req;
`endif
    end

    always_comb begin : fsm_next
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_id_nx    = r_grant_id;
        w_ptr_nx   = r_ptr;
        w_do_arb   = 1'b0;
        w_release  = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
        w_hold_nx  = r_hold_cnt;
`endif

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_do_arb = 1'b1;
                end
            end
            S_GRANT: begin
                if (w_keep) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
                    if (!w_limit) begin
                        w_hold_nx = r_hold_cnt + 1'b1;
                    end
`endif
                end else if (w_others) begin
                    w_do_arb = 1'b1;
                end else begin
                    w_release = 1'b1;
                end
            end
            default: begin
                w_release = 1'b1;
            end
        endcase

        if (w_do_arb && w_found) begin
            w_state_nx         = S_GRANT;
            w_grant_nx         = '0;
            w_grant_nx[w_win]  = 1'b1;
            w_id_nx            = w_win;
            w_ptr_nx           = (w_win == IW'(N - 1)) ? '0 : w_win + 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
            w_hold_nx          = '0;
`endif
        end

        if (w_release) begin
            w_state_nx = S_IDLE;
            w_grant_nx = '0;
            w_id_nx    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_valid    <= 1'b0;
            r_grant_id <= '0;
            r_ptr      <= '0;
`ifdef RR_ARB_HOLD_LIMIT_EN
            r_hold_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_grant    <= w_grant_nx;
            r_valid    <= |w_grant_nx;
            r_grant_id <= w_id_nx;
            r_ptr      <= w_ptr_nx;
`ifdef RR_ARB_HOLD_LIMIT_EN
            r_hold_cnt <= w_hold_nx;
`endif
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_id    = r_grant_id;

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_valid:  assert property (@(posedge clk) disable iff (rst) grant_valid == (|grant));
    a_id:     assert property (@(posedge clk) disable iff (rst)
                               (grant == '0) ? (grant_id == '0) : grant[grant_id]);

endmodule

// File: tb/tb_rr_arbiter_hold_n.sv
// Table-driven bench for rr_arbiter_hold_n (N=4, MAX_HOLD=4); expectations queued at drive time.
module tb_rr_arbiter_hold_n;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    rr_arbiter_hold_n #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    function automatic void add(string name, logic r, logic [3:0] rq, logic [3:0] ex);
        vec_t v;
        v.name = name;
        v.rst  = r;
        v.req  = rq;
        v.exp  = ex;
        vecs.push_back(v);
    endfunction

    function automatic logic [1:0] id_of(logic [3:0] g);
        for (int i = 0; i < 4; i++) begin
            if (g[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst;
        req = v.req;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check({e.name, "_grant"}, 32'(grant), 32'(e.exp));
            check({e.name, "_valid"}, 32'(grant_valid), 32'(|e.exp));
            check({e.name, "_id"}, 32'(grant_id), 32'(id_of(e.exp)));
        end
    endtask

    task automatic step(string name, logic r, logic [3:0] rq, logic [3:0] ex);
        vec_t v;
        v.name = name;
        v.rst  = r;
        v.req  = rq;
        v.exp  = ex;
        apply(v);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;

        add("rst", 1'b1, 4'b0000, 4'b0000);
        add("rst", 1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) add("t1_idle", 1'b0, 4'b0000, 4'b0000);

        // Every owner drops req for one cycle after two grant cycles.
        add("t2_a", 1'b0, 4'b1111, 4'b0001);
        add("t2_b", 1'b0, 4'b1111, 4'b0001);
        add("t2_c", 1'b0, 4'b1110, 4'b0010);
        add("t2_d", 1'b0, 4'b1111, 4'b0010);
        add("t2_e", 1'b0, 4'b1101, 4'b0100);
        add("t2_f", 1'b0, 4'b1111, 4'b0100);
        add("t2_g", 1'b0, 4'b1011, 4'b1000);
        add("t2_h", 1'b0, 4'b1111, 4'b1000);
        add("t2_i", 1'b0, 4'b0111, 4'b0001);
        add("t2_j", 1'b0, 4'b0000, 4'b0000);

        // Serve 1 (ptr->2), then 0011 wraps to 0 (ptr->1), proved by 1111 picking 1.
        add("t3_a", 1'b0, 4'b0010, 4'b0010);
        add("t3_b", 1'b0, 4'b0000, 4'b0000);
        add("t3_wrap", 1'b0, 4'b0011, 4'b0001);
        add("t3_c", 1'b0, 4'b0000, 4'b0000);
        add("t3_ptr", 1'b0, 4'b1111, 4'b0010);
        add("t3_d", 1'b0, 4'b0000, 4'b0000);

        for (int i = 0; i < 10; i++) add("t4_hold", 1'b0, 4'b1000, 4'b1000);
        add("t4_drop", 1'b0, 4'b0000, 4'b0000);
        add("t4_idle", 1'b0, 4'b0000, 4'b0000);

        foreach (vecs[i]) apply(vecs[i]);

        // Hold limit: req[0] held, req[2] joins; ptr=0 entering.
        step("t5_a", 1'b0, 4'b0001, 4'b0001);
        step("t5_b", 1'b0, 4'b0101, 4'b0001);
        step("t5_c", 1'b0, 4'b0101, 4'b0001);
        step("t5_d", 1'b0, 4'b0101, 4'b0001);
        step("t5_e", 1'b0, 4'b0101, LIM ? 4'b0100 : 4'b0001);
        step("t5_f", 1'b0, 4'b0101, LIM ? 4'b0100 : 4'b0001);
        step("t5_g", 1'b0, 4'b0100, 4'b0100);
        step("t5_h", 1'b0, 4'b0000, 4'b0000);

        // Reset mid-grant clears the grant and the pointer.
        step("t6_a", 1'b0, 4'b0100, 4'b0100);
        step("t6_rst", 1'b1, 4'b1111, 4'b0000);
        step("t6_b", 1'b0, 4'b1111, 4'b0001);
        step("t6_c", 1'b0, 4'b0000, 4'b0000);

        // Saturated hold counter pre-empts as soon as another request appears.
        for (int i = 0; i < 6; i++) step("t7_sat", 1'b0, 4'b1000, 4'b1000);
        step("t7_pre", 1'b0, 4'b1001, LIM ? 4'b0001 : 4'b1000);
        step("t7_end", 1'b0, 4'b0000, 4'b0000);

        // One-cycle request glitch in IDLE still earns a grant.
        step("t8_glitch", 1'b0, 4'b0100, 4'b0100);
        step("t8_a", 1'b0, 4'b0000, 4'b0000);
        step("t8_b", 1'b0, 4'b0000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
